p_s_tx: RTL
===========

Name: p_s_tx

Overview:
- Parallel-to-serial transmitter placed directly upstream of the byte deserializer.
- Accepts bytes on a valid/ready interface and buffers them in a small FIFO.
- Sends each byte MSB first on Dbit_out, framed by Dbit_ena: high for exactly 8 cycles, then low for a fixed gap.
- Both outputs update on the rising edge, so they are stable at the deserializer's falling-edge sampling point.

Parameters:
- DEPTH, 4, FIFO depth in bytes; power of two, at least 2.
- GAP, 1, number of Dbit_ena-low cycles between consecutive frames; at least 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- din  input  8  parallel byte to send.
- din_valid  input  1  din holds a byte offered for transmission.
- din_ready  output  1  FIFO can accept a byte this cycle.
- Dbit_out  output  1  serial data, MSB first.
- Dbit_ena  output  1  frame enable; high during the 8 bit cycles of a frame.
- tx_done  output  1  one-cycle pulse after the last bit of a frame.
- busy  output  1  FIFO not empty or a frame/gap in progress.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clk.
  - FIFO emptied: count=0, pointers=0.
  - State=IDLE, Dbit_out=0, Dbit_ena=0, tx_done=0, din_ready=1, busy=0.
- Push: occurs when din_valid && din_ready at a rising edge; din is written at the tail.
  - din_ready = (count != DEPTH), derived from registered count.
  - Offers made while din_ready=0 are ignored; the source must hold din and din_valid.
- Pop happens only in the IDLE→SHIFT or GAP→SHIFT transition.
  - Push and pop on the same edge: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- States:
  - IDLE
    - FIFO non-empty: load shift register with the head byte and pop.
    - Same edge sets Dbit_ena=1, Dbit_out=head[7], bitcnt=0, state→SHIFT.
    - Otherwise Dbit_ena=0 and Dbit_out=0.
  - SHIFT
    - bitcnt<7: shift left; Dbit_out takes the next bit; bitcnt+1.
    - bitcnt==7: Dbit_ena=0, Dbit_out=0, tx_done=1 for one cycle, gapcnt=0, state→GAP.
  - GAP
    - Dbit_ena stays 0; gapcnt increments each cycle.
    - On the edge ending gap cycle GAP: FIFO non-empty → load/pop exactly as in IDLE, state→SHIFT; otherwise state→IDLE.
- Timing:
  - A byte pushed into an empty, idle block at edge N drives Dbit_ena=1 with bit7 after edge N+1.
  - Bit k (7..0) is valid for the cycle after edge N+1+(7−k).
  - Back-to-back frame period is exactly 8+GAP cycles.
  - Dbit_ena is never high for more or fewer than 8 consecutive cycles, except when cut short by reset.
- busy = (state != IDLE) || (count != 0).
- Reset mid-frame: the frame is aborted and Dbit_ena drops after the reset edge. The downstream stage sees the enable fall and discards the partial byte. Queued bytes are lost.
- din_valid is ignored while rst=1.

Test Plan:
- Single byte: push 8'hA5 at edge 0, GAP=1 → Dbit_ena high after edges 1–8, Dbit_out=1,0,1,0,0,1,0,1; tx_done pulse after edge 9; busy low after edge 10.
- Back-to-back: push 8'h3C, 8'hC3, 8'hFF, 8'h00 on consecutive edges → four frames in order, each 8 cycles high separated by exactly 1 low cycle; deserializer model recovers 3C, C3, FF, 00.
- Full FIFO: hold din_valid high with 6 distinct bytes starting at edge 0.
  - Expected: 5 accepts on edges 0–4 (first byte is popped at edge 1, so the FIFO fills to 4).
  - din_ready=0 from edge 5 until the edge after the next pop (edge 10); the held byte is accepted there.
  - No byte lost or duplicated.
- GAP=3 parameter run: two queued bytes → exactly 3 low cycles between frames; tx_done pulses 11 cycles apart.
- Reset mid-frame: push 8'h81, assert rst for one edge after bit 4 → Dbit_ena=0, Dbit_out=0, din_ready=1, busy=0 after that edge. A following push of 8'h7E is transmitted correctly.
- Same-edge push/pop: FIFO holds 2 bytes at the GAP→SHIFT edge and a push occurs on that edge → count stays 2 and the byte order is preserved.

Source files
------------

// File: rtl/p_s_tx.sv
// Parallel-to-serial byte transmitter: small FIFO in front of an MSB-first shifter
// that frames each byte with an 8-cycle enable followed by a fixed low gap.
module p_s_tx #(
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       Dbit_out,
    output logic       Dbit_ena,
    output logic       tx_done,
    output logic       busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(GAP + 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    state_t        state_reg, state_next;
    logic [7:0]    shift_reg, shift_next;
    logic [2:0]    bitcnt_reg, bitcnt_next;
    logic [GW-1:0] gapcnt_reg, gapcnt_next;
    logic          dbit_out_reg, dbit_out_next;
    logic          dbit_ena_reg, dbit_ena_next;
    logic          tx_done_reg, tx_done_next;

    logic          push;
    logic          pop;
    logic          load;
    logic          fifo_empty;
    logic [7:0]    head;

    assign din_ready  = (count_reg != FULL);
    assign fifo_empty = (count_reg == '0);
    assign push       = din_valid && din_ready && !rst;
    // The head must be visible on the loading edge itself, so the read is combinational.
    assign head       = mem[rd_ptr_reg];

    assign Dbit_out = dbit_out_reg;
    assign Dbit_ena = dbit_ena_reg;
    assign tx_done  = tx_done_reg;
    assign busy     = (state_reg != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bitcnt_next   = bitcnt_reg;
        gapcnt_next   = gapcnt_reg;
        dbit_out_next = dbit_out_reg;
        dbit_ena_next = dbit_ena_reg;
        tx_done_next  = 1'b0;
        load          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                dbit_ena_next = 1'b0;
                dbit_out_next = 1'b0;
                load          = !fifo_empty;
            end
            ST_SHIFT: begin
                if (bitcnt_reg != 3'd7) begin
                    shift_next    = {shift_reg[6:0], 1'b0};
                    dbit_out_next = shift_reg[6];
                    bitcnt_next   = bitcnt_reg + 3'd1;
                end else begin
                    dbit_ena_next = 1'b0;
                    dbit_out_next = 1'b0;
                    tx_done_next  = 1'b1;
                    gapcnt_next   = '0;
                    state_next    = ST_GAP;
                end
            end
            ST_GAP: begin
                gapcnt_next = gapcnt_reg + GW'(1);
                if (gapcnt_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                    load       = !fifo_empty;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Loading the head byte puts bit 7 on the line on the same edge as the pop.
        if (load) begin
            shift_next    = head;
            dbit_out_next = head[7];
            dbit_ena_next = 1'b1;
            bitcnt_next   = 3'd0;
            state_next    = ST_SHIFT;
        end
    end

    assign pop = load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            bitcnt_reg   <= '0;
            gapcnt_reg   <= '0;
            dbit_out_reg <= 1'b0;
            dbit_ena_reg <= 1'b0;
            tx_done_reg  <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bitcnt_reg   <= bitcnt_next;
            gapcnt_reg   <= gapcnt_next;
            dbit_out_reg <= dbit_out_next;
            dbit_ena_reg <= dbit_ena_next;
            tx_done_reg  <= tx_done_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule
